// File: rtl/iic_scl_gen.sv
// SCL and sample-clock generator for the IIC master: mode-selectable divider, clean park on en=0, edge strobes.
// Optional clock-stretch detection against scl_bus is compiled in when IIC_SCL_STRETCH_EN is defined.
module iic_scl_gen #(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned STD_IC_FREQ  = 100_000,
  parameter int unsigned FAST_IC_FREQ = 400_000,
  parameter int unsigned HS_IC_FREQ   = 3_400_000,
  parameter int unsigned SAMPLE_RATIO = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       scl_bus,
  output logic       scl_o,
  output logic       sample_clk,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       stretching,
  output logic       cfg_err
);

  localparam int unsigned PW = $clog2(SAMPLE_RATIO);
  localparam logic [PW-1:0] LAST_PH = PW'(SAMPLE_RATIO - 1);
  localparam logic [PW-1:0] HALF_PH = PW'(SAMPLE_RATIO / 2);

  localparam int unsigned RAW_STD  = SYS_CLK_FREQ / (STD_IC_FREQ  * SAMPLE_RATIO * 2);
  localparam int unsigned RAW_FAST = SYS_CLK_FREQ / (FAST_IC_FREQ * SAMPLE_RATIO * 2);
  localparam int unsigned RAW_HS   = SYS_CLK_FREQ / (HS_IC_FREQ   * SAMPLE_RATIO * 2);
  localparam logic [15:0] DIV_STD  = (RAW_STD  == 0) ? 16'd1 : 16'(RAW_STD);
  localparam logic [15:0] DIV_FAST = (RAW_FAST == 0) ? 16'd1 : 16'(RAW_FAST);
  localparam logic [15:0] DIV_HS   = (RAW_HS   == 0) ? 16'd1 : 16'(RAW_HS);

`ifdef IIC_SCL_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, STRETCH, PARK} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   div_cnt_reg, div_cnt_next;
  logic [15:0]   half_div_reg, half_div_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic          scl_reg, scl_next;
  logic          sample_reg, sample_next;
  logic          stretch_reg, stretch_next;
  logic          cfg_err_reg, cfg_err_next;
  logic          scl_d_reg;

  logic [15:0]   div_sel;
  logic          sel_err;
  logic          tc, rise, parking;
  logic [PW-1:0] phase_inc;

  always_comb begin
    div_sel = DIV_STD;
    sel_err = (RAW_STD == 0);
    case (mode)
      2'd1:    begin div_sel = DIV_FAST; sel_err = (RAW_FAST == 0); end
      2'd2:    begin div_sel = DIV_HS;   sel_err = (RAW_HS   == 0); end
      2'd3:    begin div_sel = DIV_STD;  sel_err = 1'b1;            end
      default: begin div_sel = DIV_STD;  sel_err = (RAW_STD  == 0); end
    endcase
  end

  assign tc        = (div_cnt_reg == half_div_reg - 16'd1);
  assign rise      = tc && !sample_reg;
  assign parking   = (state_reg == PARK) || (!en && state_reg != IDLE);
  assign phase_inc = (phase_reg == LAST_PH) ? '0 : phase_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    half_div_next = half_div_reg;
    phase_next    = phase_reg;
    scl_next      = scl_reg;
    sample_next   = sample_reg;
    stretch_next  = stretch_reg;
    cfg_err_next  = en ? cfg_err_reg : 1'b0;

    if (state_reg == IDLE) begin
      scl_next      = 1'b1;
      sample_next   = 1'b0;
      div_cnt_next  = '0;
      phase_next    = '0;
      stretch_next  = 1'b0;
      half_div_next = div_sel;
      cfg_err_next  = en && sel_err;
      if (en) begin
        state_next = RUN;
        // Start one step before the wrap so the first sample_clk rise lands on phase 0 (scl falls).
        phase_next = LAST_PH;
      end
    end else begin
      if (tc) begin
        div_cnt_next = '0;
        sample_next  = !sample_reg;
      end else begin
        div_cnt_next = div_cnt_reg + 16'd1;
      end

      if (parking) begin
        state_next   = PARK;
        stretch_next = 1'b0;
        // A rise only reaches here with scl low, so parking can only finish the low half, never wrap.
        if (scl_reg && !sample_reg) begin
          state_next   = IDLE;
          div_cnt_next = '0;
          phase_next   = '0;
          sample_next  = 1'b0;
        end else if (rise) begin
          phase_next = phase_inc;
          scl_next   = (phase_inc >= HALF_PH);
        end
      end else if (rise) begin
        if (state_reg == STRETCH) begin
          if (scl_bus) begin
            state_next   = RUN;
            stretch_next = 1'b0;
          end
        end else if (STRETCH_EN && scl_reg && !scl_bus) begin
          state_next   = STRETCH;
          stretch_next = 1'b1;
        end else begin
          phase_next = phase_inc;
          scl_next   = (phase_inc >= HALF_PH);
          if (phase_reg == LAST_PH) begin
            half_div_next = div_sel;
            cfg_err_next  = cfg_err_reg || sel_err;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      half_div_reg <= DIV_STD;
      phase_reg    <= '0;
      scl_reg      <= 1'b1;
      sample_reg   <= 1'b0;
      stretch_reg  <= 1'b0;
      cfg_err_reg  <= 1'b0;
      scl_d_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      half_div_reg <= half_div_next;
      phase_reg    <= phase_next;
      scl_reg      <= scl_next;
      sample_reg   <= sample_next;
      stretch_reg  <= stretch_next;
      cfg_err_reg  <= cfg_err_next;
      scl_d_reg    <= scl_reg;
    end
  end

  assign scl_o      = scl_reg;
  assign sample_clk = sample_reg;
  assign scl_rise   = scl_reg && !scl_d_reg;
  assign scl_fall   = !scl_reg && scl_d_reg;
  assign stretching = STRETCH_EN ? stretch_reg : 1'b0;
  assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_iic_scl_gen.sv
// Scoreboard bench for iic_scl_gen: expected SCL edge cycles are queued by the stimulus and
// consumed by an edge monitor; level checks cover reset, cfg_err, sample_clk and parking.
module tb_iic_scl_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       scl_bus;
  logic       scl_o, sample_clk, scl_rise, scl_fall, stretching, cfg_err;

  iic_scl_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .scl_bus    (scl_bus),
    .scl_o      (scl_o),
    .sample_clk (sample_clk),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .stretching (stretching),
    .cfg_err    (cfg_err)
  );

`ifdef IIC_SCL_STRETCH_EN
  localparam bit STR = 1'b1;
`else
  localparam bit STR = 1'b0;
`endif

  typedef struct {
    bit rise;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input bit r, input int c);
    ev_t e;
    e.rise = r;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_scl_o"},      scl_o,      1);
    check({tag, "_sample_clk"}, sample_clk, 0);
    check({tag, "_scl_rise"},   scl_rise,   0);
    check({tag, "_scl_fall"},   scl_fall,   0);
    check({tag, "_stretching"}, stretching, 0);
    check({tag, "_cfg_err"},    cfg_err,    0);
  endtask

  // Edge monitor: every strobe pops one expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (scl_rise || scl_fall)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_edge: rise=%0b fall=%0b at cyc %0d, no edge expected",
                   scl_rise, scl_fall, cyc);
        end else begin
          e = exp_q.pop_front();
          check("edge_kind", {scl_rise, scl_fall}, e.rise ? 2 : 1);
          check("edge_cyc", cyc, e.cyc);
          $display("edge %s at cyc %0d (expected cyc %0d)", scl_rise ? "rise" : "fall", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; scl_bus = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Standard mode, then switch to fast at phase 2; park while scl is low.
    k = cyc + 1;
    en = 1'b1;
    push(0, k + 31);  push(1, k + 279); push(0, k + 527);
    push(1, k + 583); push(0, k + 639); push(1, k + 695);
    push(0, k + 751); push(1, k + 807);
    at(k + 31);  check("std_sample_hi",  sample_clk, 1);
    at(k + 40);  check("std_cfg_err",    cfg_err,    0);
                 check("std_scl_low",    scl_o,      0);
    at(k + 62);  check("std_sample_lo",  sample_clk, 0);
    at(k + 93);  check("std_sample_hi2", sample_clk, 1);
    at(k + 160); mode = 2'd1;
    at(k + 540); check("fast_cfg_err",   cfg_err,    0);
    at(k + 760); en = 1'b0;
    at(k + 800); check("park_scl_low",   scl_o,      0);
    at(k + 830); check("park_scl_hi",    scl_o,      1);
                 check("park_sample",    sample_clk, 0);
    at(k + 900); check("park_sample2",   sample_clk, 0);

    // High-speed mode: divisor clamps to 1.
    mode = 2'd2;
    @(negedge clk);
    k = cyc + 1;
    en = 1'b1;
    push(0, k + 1); push(1, k + 9); push(0, k + 17); push(1, k + 25);
    at(k + 1);  check("hs_sample_hi", sample_clk, 1);
    at(k + 2);  check("hs_sample_lo", sample_clk, 0);
    at(k + 5);  check("hs_cfg_err",   cfg_err,    1);
    at(k + 26); en = 1'b0;
    at(k + 35); check("hs_cfg_clear", cfg_err,    0);
                check("hs_park_scl",  scl_o,      1);

    // Reserved mode: standard timing with cfg_err.
    mode = 2'd3;
    @(negedge clk);
    k = cyc + 1;
    en = 1'b1;
    push(0, k + 31); push(1, k + 279);
    at(k + 40);  check("rsv_cfg_err",  cfg_err,    1);
    at(k + 300); en = 1'b0;
    at(k + 340); check("rsv_park_scl", scl_o,      1);
                 check("rsv_park_smp", sample_clk, 0);
                 check("rsv_cfg_clr",  cfg_err,    0);

    // Fast mode with a slave holding SCL low for 300 clk after scl rises.
    mode = 2'd1;
    @(negedge clk);
    k = cyc + 1;
    en = 1'b1;
    push(0, k + 7); push(1, k + 63);
    if (STR) begin
      push(0, k + 427);
    end else begin
      push(0, k + 119); push(1, k + 175); push(0, k + 231); push(1, k + 287);
      push(0, k + 343); push(1, k + 399); push(0, k + 455);
    end
    at(k + 63);  scl_bus = 1'b0;
    at(k + 76);  check("str_before",     stretching, 0);
    at(k + 78);  check("str_entered",    stretching, STR ? 1 : 0);
    at(k + 200); check("str_hold",       stretching, STR ? 1 : 0);
                 check("str_scl_hi",     scl_o,      1);
    at(k + 363); scl_bus = 1'b1;
    at(k + 370); check("str_still",      stretching, STR ? 1 : 0);
    at(k + 372); check("str_released",   stretching, 0);
    at(k + 460); check("scl_low_pre_rst", scl_o,     0);

    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    repeat (3) @(negedge clk);
    check_reset_values("held_reset");
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iic_scl_gen.md
Name: iic_scl_gen

Overview:
- Upstream timing stage for the IIC master.
- Derives from the system clock the free-running SCL waveform (`scl_o`, driven into the master's `scl_in`) and the sample clock (`sample_clk`, driven into the master's `sample_scl_reg`).
- Mode-selectable bus rate (standard, fast, high-speed), clean enable/disable, edge strobes, and optional SCL clock-stretch detection against the physical bus line.

Parameters:
- SYS_CLK_FREQ, 50_000_000, system clock frequency in Hz.
- STD_IC_FREQ, 100_000, standard-mode SCL rate in Hz.
- FAST_IC_FREQ, 400_000, fast-mode SCL rate in Hz.
- HS_IC_FREQ, 3_400_000, high-speed-mode SCL rate in Hz.
- SAMPLE_RATIO, 8, sample_clk periods per SCL period; must be even and ≥4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = generate clocks; 0 = park.
- mode  input  2  0 = std, 1 = fast, 2 = hs, 3 = reserved (treated as std, sets cfg_err).
- scl_bus  input  1  sampled physical SCL line (already synchronised externally); used only for stretch detection.
- scl_o  output  1  generated SCL, goes to master scl_in.
- sample_clk  output  1  registered square wave, goes to master sample_scl_reg.
- scl_rise  output  1  one-clk pulse when scl_o goes 0→1.
- scl_fall  output  1  one-clk pulse when scl_o goes 1→0.
- stretching  output  1  high while a slave holds SCL low.
- cfg_err  output  1  sticky; set by an invalid mode or a divisor clamp; cleared by reset or en=0.

Behaviour:
- Reset values: scl_o=1, sample_clk=0, scl_rise=0, scl_fall=0, stretching=0, cfg_err=0; internal state IDLE, div_cnt=0, phase=0.
- Divisor:
  - half_div = SYS_CLK_FREQ/(FREQ_mode*SAMPLE_RATIO*2), integer truncation, 16-bit.
  - If the result is 0, use 1 and set cfg_err.
  - Defaults give std=31, fast=7, hs=0→1.
- sample_clk: div_cnt counts 0..half_div-1. On terminal count, sample_clk toggles and div_cnt returns to 0, so the sample_clk period is 2*half_div clk.
- Phase counter:
  - Advances 0..SAMPLE_RATIO-1 on each clk cycle in which sample_clk toggles 0→1, then wraps to 0.
  - scl_o=0 for phase < SAMPLE_RATIO/2 and 1 otherwise. scl_o is registered and updates in the same cycle as the phase change.
- Mode latch:
  - The active half_div is latched from mode only in IDLE or on a phase wrap (SCL period boundary).
  - A mode change mid-period never shortens the current SCL phase.
- State machine:
  - IDLE: outputs parked (scl_o=1, sample_clk=0), counters 0, cfg_err cleared. en=1 → RUN. The first rising sample_clk edge occurs half_div clk later, with phase=0, so scl_o falls.
  - RUN: normal generation. The transition from phase SAMPLE_RATIO/2-1 to SAMPLE_RATIO/2 raises scl_o. If stretch is enabled, at the next sample_clk rising edge while scl_o=1 and scl_bus=0 → STRETCH.
  - STRETCH: stretching=1, phase frozen, scl_o held 1 (released), sample_clk keeps toggling so the master keeps sampling. On a sample_clk rising edge with scl_bus=1 → RUN, stretching=0, and the phase resumes with the next increment.
  - en=0 in any state: enter PARK. PARK waits until scl_o=1 (completing the current low half if needed) and sample_clk=0, then → IDLE. SCL is therefore never left low and never glitches.
- Edge strobes: scl_rise / scl_fall are asserted exactly one clk, in the cycle after scl_o changes (compare against a registered copy of scl_o).
- Simultaneous events:
  - en falling in the same cycle as a phase wrap: PARK takes priority and the mode is not relatched.
  - Reset mid-operation: immediate return to reset values.
- Widths: div_cnt 16 bits; phase $clog2(SAMPLE_RATIO) bits.

Optional Feature:
- Macro IIC_SCL_STRETCH_EN.
- Defined: STRETCH state and `stretching` output behave as above.
- Undefined: scl_bus is ignored, STRETCH is never entered, and stretching is tied to 0.

Test Plan:
- Reset then en=1, mode=0, defaults → sample_clk period 62 clk, scl_o period 496 clk at 50% duty, first scl_fall after 31 clk, cfg_err=0.
- mode=1 → sample_clk period 14 clk, scl_o period 112 clk, each of scl_rise/scl_fall pulses once per SCL period and is 1 clk wide.
- mode=2 → half_div clamped to 1, sample_clk period 2 clk, scl_o period 16 clk, cfg_err=1. mode=3 → std timing, cfg_err=1.
- Switch from mode 0 to mode 1 at phase 2 → current 496-clk period completes unchanged, next period is 112 clk.
- (IIC_SCL_STRETCH_EN) Hold scl_bus=0 for 300 clk after scl_o rises → stretching=1, phase frozen, scl_o stays 1. Release scl_bus → stretching drops at the next sample_clk rising edge and the high phase completes.
- Drop en while scl_o=0 → scl_o returns to 1 at the normal half-period, then sample_clk parks at 0 and no further edges occur. Assert rst_n=0 mid-run → all outputs return to reset values immediately.
